sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock synchronous FIFO buffering width-bit words between a producer and a consumer.
//  Occupancy is reported by full and empty flags.
//  Read data is registered, so dout is valid one clock after an accepted read.
//  General-purpose rate/burst decoupler; instantiated under the DUT name fifo.
// PARAMETERS
//  width  8   data word width in bits
//  depth  16  number of storage entries; must equal 2**add
//  add    4   address (pointer) width in bits
// PORTS
//  clk   in   1      clock; all state updates on posedge
//  rst   in   1      asynchronous, active-low reset (0 = reset asserted)
//  wr    in   1      write request; din sampled at posedge
//  rd    in   1      read request
//  din   in   width  write data
//  full  out  1      high when depth entries are stored
//  empty out  1      high when 0 entries are stored
//  dout  out  width  registered read data
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): wptr=0, rptr=0, count=0, dout=0, empty=1, full=0.
//    Memory contents are not reset. Reset applied mid-operation discards all stored data.
//  - Pointers: wptr and rptr are add+1 bits wide. Bit [add-1:0] is the RAM address; the MSB is the wrap bit.
//  - Flags are combinational from the pointers:
//      empty = (wptr == rptr)
//      full  = (addresses equal) && (MSBs differ)
//  - Write accept: wr_en = wr && (!full || rd). On wr_en: mem[wptr[add-1:0]] <= din; wptr <= wptr+1.
//  - Read accept: rd_en = rd && !empty. On rd_en: dout <= mem[rptr[add-1:0]]; rptr <= rptr+1.
//    Latency: data appears on dout at the edge that accepts the read.
//  - dout holds its last value when no read is accepted.
//  - Write while full, without rd: ignored. No overwrite; pointers unchanged.
//  - Read while empty: ignored. dout and rptr unchanged.
//  - Simultaneous wr and rd:
//      * not full, not empty: both accepted; occupancy unchanged.
//      * full: both accepted. The read returns the oldest word. The write fills the freed slot; full stays 1.
//      * empty: only the write is accepted. There is no fall-through; empty deasserts after the edge.
//  - Wrap-around: addresses roll over from depth-1 to 0. The MSB toggles on each pass.
//    Order is preserved indefinitely.
//  - No X propagation out of dout: dout is reset, and is only loaded from written entries.
// STRUCTURE
//  - Shared package: parameter defaults (WIDTH=8, DEPTH=16, ADDR=4).
//  - One sub-module, fifo_mem: depth x width RAM with one synchronous write port and one registered read port.
//    Read data is registered into dout.
//  - Pointer, flag and accept logic stay in the top level.
// TESTING
//  1. Reset: hold rst=0 for 2 cycles -> empty=1, full=0, dout=0. Release rst=1.
//  2. Fill: write 16 words 0x10..0x1F, rd=0 -> full=1 after the 16th edge.
//     A 17th write of 0xAA is ignored.
//  3. Drain: 16 reads, wr=0 -> dout = 0x10..0x1F in order, each one cycle after its read.
//     empty=1 after the last read; a 17th read leaves dout=0x1F.
//  4. Concurrent: preload 4 words, then 8 cycles of wr=rd=1 with new data -> FIFO-ordered output.
//     Occupancy stays 4; no flag change.
//  5. Boundaries: wr=rd=1 when full -> oldest word out, full stays 1.
//     wr=rd=1 when empty -> dout unchanged, empty=0 next cycle.
//  6. Wrap plus mid-op reset: cycle 40 words through, checking order across pointer wrap.
//     Assert rst=0 with 5 words stored -> flags and dout return to reset values immediately.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared default sizing for the synchronous FIFO and its storage.
// Revision: 1.0
`default_nettype none

package sync_fifo_pkg;
    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 16;
    localparam int c_ADDR  = 4;
endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x WIDTH RAM, one synchronous write port, one registered read port.
// Revision: 1.0
`default_nettype none

module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int DEPTH = c_DEPTH,
    parameter int ADDR  = c_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ADDR-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A read of the slot being rewritten in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, full/empty flags, registered read data.
// Revision: 1.0
`default_nettype none

module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int DEPTH = c_DEPTH,
    parameter int ADDR  = c_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [ADDR:0] r_wptr;
    logic [ADDR:0] r_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_rd_en;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR-1:0] == r_rptr[ADDR-1:0]) && (r_wptr[ADDR] != r_rptr[ADDR]);

    // A concurrent read frees a slot, so a write is still taken when full.
    assign w_wr_en = wr && (!w_full || rd);
    assign w_rd_en = rd && !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + {{ADDR{1'b0}}, 1'b1};
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + {{ADDR{1'b0}}, 1'b1};
            end
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr[ADDR-1:0]),
        .i_wdata (din),
        .i_re    (w_rd_en),
        .i_raddr (r_rptr[ADDR-1:0]),
        .o_rdata (dout)
    );

    assign full  = w_full;
    assign empty = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus against a queue-based reference of the FIFO.
// Revision: 1.0
`default_nettype none

module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = '0;
    logic       full;
    logic       empty;
    logic [7:0] dout;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q[$];
    logic [7:0] exp_dout = '0;

    sync_fifo fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (rd),
        .din   (din),
        .full  (full),
        .empty (empty),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; the reference decides acceptance from occupancy alone.
    task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
        bit wa, ra;
        @(negedge clk);
        wr  = w;
        rd  = r;
        din = d;
        ra  = r && (q.size() > 0);
        wa  = w && ((q.size() < c_DEPTH) || r);
        @(posedge clk);
        if (ra) exp_dout = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        check({tag, ".full"},  {31'd0, full},  {31'd0, q.size() == c_DEPTH});
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
        check({tag, ".dout"},  {24'd0, dout},  {24'd0, exp_dout});
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.empty", {31'd0, empty}, 32'd1);
        check("rst.full",  {31'd0, full},  32'd0);
        check("rst.dout",  {24'd0, dout},  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill, then an ignored write while full
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 8'h10 + 8'(i));
        check("fill.full16", {31'd0, full}, 32'd1);
        step("fill17", 1'b1, 1'b0, 8'hAA);

        // Drain, then an ignored read while empty
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00);
        check("drain.last", {24'd0, dout}, 32'h1F);
        step("drain17", 1'b0, 1'b1, 8'h00);
        check("drain17.hold", {24'd0, dout}, 32'h1F);

        // Concurrent traffic at occupancy 4
        for (int i = 0; i < 4; i++) step("pre", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 8; i++) step("conc", 1'b1, 1'b1, 8'($urandom));

        // Boundary: wr=rd when full
        while (q.size() < c_DEPTH) step("tofull", 1'b1, 1'b0, 8'($urandom));
        step("fullrw", 1'b1, 1'b1, 8'h5A);
        check("fullrw.full", {31'd0, full}, 32'd1);

        // Boundary: wr=rd when empty
        while (q.size() > 0) step("toempty", 1'b0, 1'b1, 8'h00);
        step("emptyrw", 1'b1, 1'b1, 8'hC3);
        check("emptyrw.empty", {31'd0, empty}, 32'd0);
        step("emptyrw.rd", 1'b0, 1'b1, 8'h00);
        check("emptyrw.data", {24'd0, dout}, 32'hC3);

        // Stream 40 words through to cross the pointer wrap several times
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, (i >= 2), 8'($urandom));
        for (int i = 0; i < 3; i++) step("top5", 1'b1, 1'b0, 8'($urandom));

        // Mid-operation asynchronous reset with 5 words stored
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst.empty", {31'd0, empty}, 32'd1);
        check("midrst.full",  {31'd0, full},  32'd0);
        check("midrst.dout",  {24'd0, dout},  32'd0);
        q.delete();
        exp_dout = '0;
        @(negedge clk);
        rst = 1'b1;
        step("postrst.wr", 1'b1, 1'b0, 8'h77);
        step("postrst.rd", 1'b0, 1'b1, 8'h00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
